// File: rtl/vfd_scan_controller.sv
// VFD grid scan sequencer: walks grids 1..GRIDS, opens the shift window, and pulses BLK/LAT per slot.
// Define VFD_SCAN_DBUF_EN to enable GRAM bank double buffering; otherwise SWAP_ACK is a frame tick.
module vfd_scan_controller #(
  parameter int unsigned PERIOD    = 3846,
  parameter int unsigned GRIDS     = 52,
  parameter int unsigned SHIFT_LEN = 288,
  parameter int unsigned BLK_W     = 120,
  parameter int unsigned LAT_W     = 3
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       EN,
  input  logic       SWAP_REQ,
  output logic       SHIFT_EN,
  output logic [5:0] GRID,
  output logic       BLK,
  output logic       LAT,
  output logic       FRAME_START,
  output logic       RD_BANK,
  output logic       SWAP_ACK
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam logic [CW-1:0] CNT_SHIFT_END = CW'(SHIFT_LEN - 1);
  localparam logic [CW-1:0] CNT_BLK_START = CW'(PERIOD - BLK_W - 1);
  localparam logic [CW-1:0] CNT_LAT_END   = CW'(PERIOD - BLK_W + LAT_W - 1);
  localparam logic [CW-1:0] CNT_LAST      = CW'(PERIOD - 1);
  localparam logic [5:0]    GRID_LAST     = 6'(GRIDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_BLANK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    grid_q, grid_d;
  logic          shift_en_q, shift_en_d;
  logic          blk_q, blk_d;
  logic          lat_q, lat_d;
  logic          frame_start_q, frame_start_d;
  logic          rd_bank_q, rd_bank_d;
  logic          swap_ack_q, swap_ack_d;
  logic          boundary_c;

`ifdef VFD_SCAN_DBUF_EN
  logic          pend_q, pend_d;
`else
  logic          unused_swap_req;
  assign unused_swap_req = SWAP_REQ;
`endif

  // State and output registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      grid_q        <= '0;
      shift_en_q    <= 1'b0;
      blk_q         <= 1'b1;
      lat_q         <= 1'b0;
      frame_start_q <= 1'b0;
      rd_bank_q     <= 1'b0;
      swap_ack_q    <= 1'b0;
`ifdef VFD_SCAN_DBUF_EN
      pend_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grid_q        <= grid_d;
      shift_en_q    <= shift_en_d;
      blk_q         <= blk_d;
      lat_q         <= lat_d;
      frame_start_q <= frame_start_d;
      rd_bank_q     <= rd_bank_d;
      swap_ack_q    <= swap_ack_d;
`ifdef VFD_SCAN_DBUF_EN
      pend_q        <= pend_d;
`endif
    end
  end

  // Slot timeline; BLK is only cleared on a slot rollover, so the first slot after IDLE stays blanked
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grid_d        = grid_q;
    shift_en_d    = shift_en_q;
    blk_d         = blk_q;
    lat_d         = lat_q;
    frame_start_d = 1'b0;
    rd_bank_d     = rd_bank_q;
    swap_ack_d    = 1'b0;
    boundary_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (EN) begin
          state_d       = ST_SHIFT;
          grid_d        = 6'd1;
          shift_en_d    = 1'b1;
          frame_start_d = 1'b1;
          boundary_c    = 1'b1;
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_SHIFT_END) begin
          state_d    = ST_HOLD;
          shift_en_d = 1'b0;
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_BLK_START) begin
          state_d = ST_BLANK;
          blk_d   = 1'b1;
          lat_d   = 1'b1;
        end
      end
      ST_BLANK: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAT_END) begin
          lat_d = 1'b0;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (EN) begin
            state_d    = ST_SHIFT;
            shift_en_d = 1'b1;
            blk_d      = 1'b0;
            if (grid_q == GRID_LAST) begin
              grid_d        = 6'd1;
              frame_start_d = 1'b1;
              boundary_c    = 1'b1;
            end else begin
              grid_d = grid_q + 6'd1;
            end
          end else begin
            state_d = ST_IDLE;
            grid_d  = '0;
            blk_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef VFD_SCAN_DBUF_EN
    // A request sampled on the boundary edge itself is folded into that boundary
    pend_d = pend_q | SWAP_REQ;
    if (boundary_c && (pend_q || SWAP_REQ)) begin
      rd_bank_d  = ~rd_bank_q;
      swap_ack_d = 1'b1;
      pend_d     = 1'b0;
    end
`else
    rd_bank_d  = 1'b0;
    swap_ack_d = boundary_c;
`endif
  end

  assign SHIFT_EN    = shift_en_q;
  assign GRID        = grid_q;
  assign BLK         = blk_q;
  assign LAT         = lat_q;
  assign FRAME_START = frame_start_q;
  assign RD_BANK     = rd_bank_q;
  assign SWAP_ACK    = swap_ack_q;

endmodule

// File: tb/tb_vfd_scan_controller.sv
// Scoreboard bench for vfd_scan_controller: stimulus queues per-slot expectations, a negedge monitor checks them.
// Shortened slot parameters keep several full 52-grid frames within a small cycle budget.
module tb_vfd_scan_controller;

  localparam int unsigned P  = 20;
  localparam int unsigned G  = 52;
  localparam int unsigned SL = 8;
  localparam int unsigned BW = 6;
  localparam int unsigned LW = 3;
`ifdef VFD_SCAN_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       EN;
  logic       SWAP_REQ;
  logic       SHIFT_EN;
  logic [5:0] GRID;
  logic       BLK;
  logic       LAT;
  logic       FRAME_START;
  logic       RD_BANK;
  logic       SWAP_ACK;

  vfd_scan_controller #(
    .PERIOD(P), .GRIDS(G), .SHIFT_LEN(SL), .BLK_W(BW), .LAT_W(LW)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .SWAP_REQ(SWAP_REQ),
    .SHIFT_EN(SHIFT_EN), .GRID(GRID), .BLK(BLK), .LAT(LAT),
    .FRAME_START(FRAME_START), .RD_BANK(RD_BANK), .SWAP_ACK(SWAP_ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit idle;
    int grid;
    bit fs;
    bit ack;
    bit bank;
    bit blk;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   t0    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick(1);
  endtask

  function automatic int st(input int j);
    return t0 + 1 + (j - 1) * P;
  endfunction

  task automatic push_slot(input int grid, input bit fs, input bit ack, input bit bank, input bit blk);
    exp_t e;
    e.idle = 1'b0; e.grid = grid; e.fs = fs; e.ack = ack; e.bank = bank; e.blk = blk;
    exp_q.push_back(e);
  endtask

  task automatic push_idle();
    exp_t e;
    e.idle = 1'b1; e.grid = 0; e.fs = 1'b0; e.ack = 1'b0; e.bank = 1'b0; e.blk = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_shift_en"}, SHIFT_EN, 0);
    check({tag, "_grid"}, GRID, 0);
    check({tag, "_blk"}, BLK, 1);
    check({tag, "_lat"}, LAT, 0);
    check({tag, "_frame_start"}, FRAME_START, 0);
    check({tag, "_rd_bank"}, RD_BANK, 0);
    check({tag, "_swap_ack"}, SWAP_ACK, 0);
  endtask

  // Monitor: pops one expectation per slot start and per return to idle
  initial begin
    bit   prev_se = 0, prev_lat = 0, prev_blk = 1, prev_bank = 0, have_prev = 0, cur_first = 1;
    int   prev_grid = 0, slot_start = 0, lat_start = 0;
    bit   start;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RSTN) begin
        prev_se = 0; prev_lat = 0; prev_blk = 1; prev_bank = 0; prev_grid = 0; have_prev = 0;
      end else begin
        start = SHIFT_EN && !prev_se;
        if (start) begin
          check("slot_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("slot_kind_idle", e.idle, 0);
            check("slot_grid", GRID, e.grid);
            check("slot_frame_start", FRAME_START, e.fs);
            check("slot_swap_ack", SWAP_ACK, e.ack);
            check("slot_rd_bank", RD_BANK, e.bank);
            check("slot_blk", BLK, e.blk);
            cur_first = e.blk;
          end
          if (have_prev) check("slot_spacing", cyc - slot_start, P);
          slot_start = cyc;
          have_prev  = 1;
        end else begin
          check("no_stray_fs_ack_bank", {FRAME_START, SWAP_ACK, RD_BANK ^ prev_bank}, 0);
        end
        if (!SHIFT_EN && prev_se) check("shift_width", cyc - slot_start, SL);
        if (LAT && !prev_lat) begin
          check("lat_offset", cyc - slot_start, P - BW);
          check("blk_before_lat", prev_blk, cur_first);
          check("blk_at_lat", BLK, 1);
          lat_start = cyc;
        end
        if (!LAT && prev_lat) check("lat_width", cyc - lat_start, LW);
        if (GRID == 0 && prev_grid != 0) begin
          check("idle_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("idle_kind", e.idle, 1);
          end
          check("idle_after_full_slot", cyc - slot_start, P);
          check("idle_blk", BLK, 1);
          check("idle_shift_en", SHIFT_EN, 0);
          check("idle_lat", LAT, 0);
          have_prev = 0;
        end
        prev_se = SHIFT_EN; prev_lat = LAT; prev_blk = BLK; prev_bank = RD_BANK; prev_grid = GRID;
      end
    end
  end

  // Stimulus
  initial begin
    RSTN = 1'b1; EN = 1'b0; SWAP_REQ = 1'b0;
    #2 RSTN = 1'b0;
    #1 check_reset_outputs("reset");
    tick(3);
    RSTN = 1'b1;
    tick(5);

    // Two full frames plus grids 1..7 of a third; requests at grids 20/40, then one on the boundary edge
    for (int j = 1; j <= 111; j++) begin
      int  g;
      bit  ack, bank;
      g    = ((j - 1) % G) + 1;
      ack  = 1'b0;
      bank = 1'b0;
      if (j == 1)        ack = !DBUF;
      else if (j == 53)  ack = 1'b1;
      else if (j == 105) ack = 1'b1;
      if (j >= 53 && j < 105) bank = DBUF;
      push_slot(g, g == 1, ack, bank, j == 1);
    end
    push_idle();
    EN = 1'b1;
    t0 = cyc;
    wait_until(st(20) + 3); SWAP_REQ = 1'b1; tick(1); SWAP_REQ = 1'b0;
    wait_until(st(40) + 3); SWAP_REQ = 1'b1; tick(1); SWAP_REQ = 1'b0;
    wait_until(st(105) - 1); SWAP_REQ = 1'b1; tick(1); SWAP_REQ = 1'b0;
    wait_until(st(111) + 5); EN = 1'b0;
    wait_until(st(111) + P + 4);

    // Request while idle applies at the first boundary; a further pending request is then reset away
    SWAP_REQ = 1'b1; tick(1); SWAP_REQ = 1'b0;
    tick(2);
    push_slot(1, 1'b1, 1'b1, DBUF, 1'b1);
    EN = 1'b1;
    t0 = cyc;
    wait_until(st(1) + 1); SWAP_REQ = 1'b1; tick(1); SWAP_REQ = 1'b0;
    tick(1);
    #2 RSTN = 1'b0;
    #1 check_reset_outputs("async_reset");
    push_slot(1, 1'b1, !DBUF, 1'b0, 1'b1);
    push_slot(2, 1'b0, 1'b0, 1'b0, 1'b0);
    push_idle();
    tick(2);
    RSTN = 1'b1;
    t0 = cyc;
    wait_until(st(2) + 3); EN = 1'b0;
    wait_until(st(2) + P + 4);

    check("expectations_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vfd_scan_controller.md
# vfd_scan_controller

Per-grid scan sequencer for the MN15439A VFD path. It owns the display refresh timeline: it walks the grid number 1..52, opens a 288-cycle shift window that enables the Tri-SPI output and GCP generator, and generates the BLK/LAT pulses that commit each grid's data. It also hands over GRAM banks to the host-side SPI writer at frame boundaries. It sits in `top` between the system clock and the TSPI, GCPCLK and GRAM blocks, and replaces the ad-hoc divider logic there.

## Interface
Parameters:
- `PERIOD`, 3846: system clocks per grid slot (12 MHz / 3120 Hz).
- `GRIDS`, 52: number of grids scanned per frame.
- `SHIFT_LEN`, 288: clocks per shift window.
- `BLK_W`, 120: BLK high width at the end of each slot, in clocks.
- `LAT_W`, 3: LAT high width, in clocks (250 ns).
- Legal configuration: `PERIOD > SHIFT_LEN + BLK_W`, `BLK_W > LAT_W`, `GRIDS <= 63`.

Ports:
- `CLK` in 1: system clock, 12 MHz.
- `RSTN` in 1: reset, asynchronous assert, active-low.
- `EN` in 1: level signal; scan runs while high.
- `SWAP_REQ` in 1: single-cycle pulse from the host writer asking for a bank swap.
- `SHIFT_EN` out 1: drives TSPI `SCE` and GCPCLK `PCE`.
- `GRID` out 6: grid currently being shifted, 1..`GRIDS`; 0 when idle.
- `BLK` out 1: display blank.
- `LAT` out 1: serial latch.
- `FRAME_START` out 1: one-cycle pulse when `GRID` becomes 1.
- `RD_BANK` out 1: GRAM bank the TSPI reads from.
- `SWAP_ACK` out 1: one-cycle pulse when a swap takes effect.

## Operation
- Every output is registered.
- Reset values: `SHIFT_EN`=0, `GRID`=0, `BLK`=1, `LAT`=0, `FRAME_START`=0, `RD_BANK`=0, `SWAP_ACK`=0. Internal state: `slot_cnt`=0, state=IDLE, swap pending=0, first-slot flag=1.
- `slot_cnt` is `$clog2(PERIOD)` bits wide and runs 0..`PERIOD-1` within each slot.
- IDLE:
  - `BLK`=1; all other outputs at their reset values.
  - When `EN`=1 → SHIFT, with `slot_cnt`←0, `GRID`←1, `SHIFT_EN`←1, `FRAME_START`←1.
- SHIFT:
  - `SHIFT_EN`=1 for `slot_cnt` 0..`SHIFT_LEN-1`.
  - At `slot_cnt`=`SHIFT_LEN-1` → HOLD, with `SHIFT_EN`←0.
- HOLD:
  - At `slot_cnt`=`PERIOD-BLK_W-1` → BLANK, with `BLK`←1 and `LAT`←1.
- BLANK:
  - `LAT` falls after `LAT_W` cycles; `BLK` stays high until the end of the slot.
  - At `slot_cnt`=`PERIOD-1`, if `EN`=1: start the next slot (`slot_cnt`←0, state SHIFT, `SHIFT_EN`←1, `BLK`←0). `GRID` increments, wrapping `GRIDS`→1; the wrap also pulses `FRAME_START`.
  - At `slot_cnt`=`PERIOD-1`, if `EN`=0: → IDLE, `GRID`←0, `BLK` stays 1.
- First slot after leaving IDLE: `BLK` stays 1 for the whole slot, because nothing has been latched yet. It is cleared at the start of the second slot.
- `EN` falling mid-slot: the current slot completes in full, including the LAT pulse; then → IDLE.
- Swap requests:
  - A `SWAP_REQ` pulse sets a pending flag.
  - At the frame boundary (the cycle `GRID` wraps to 1), a pending flag causes `RD_BANK` to toggle, `SWAP_ACK` to pulse, and the flag to clear.
  - A `SWAP_REQ` arriving in the boundary cycle itself is taken at that boundary.
  - Several requests within one frame collapse into one swap.
  - The first `FRAME_START` out of IDLE is also a frame boundary, so a pending swap applies there.
- `RSTN` low in any state: all outputs go to reset values immediately; the pending swap is discarded.

## Timing
- Slot length is exactly `PERIOD` clocks; frame length is `GRIDS`×`PERIOD` clocks.
- `EN` to first `SHIFT_EN`: 1 cycle (first edge sampling `EN`=1).
- `SHIFT_EN` to `BLK`/`LAT` rise: `PERIOD-BLK_W-SHIFT_LEN` cycles after `SHIFT_EN` falls.
- `BLK` low to next `SHIFT_EN`: same edge; `BLK` and `SHIFT_EN` change on the same clock.
- `GRID` is stable for the whole slot and changes only on the same edge that raises `SHIFT_EN`.
- `SWAP_ACK`, `FRAME_START` and the `RD_BANK` change all occur on the same edge.
- `RD_BANK` never changes while `SHIFT_EN`=1.

## Configuration
- `VFD_SCAN_DBUF_EN` defined:
  - Double buffering as described above.
- `VFD_SCAN_DBUF_EN` undefined:
  - `RD_BANK` is tied to 0.
  - `SWAP_REQ` is ignored and no pending flag is built.
  - `SWAP_ACK` pulses at every frame boundary, as a frame-sync tick for the host.

## Test plan
- Reset, then `EN`=1 at cycle 10: `SHIFT_EN` high cycles 11..298, `GRID`=1, `FRAME_START` pulse at 11; `BLK` stays 1 through the first slot; `LAT` high for 3 cycles starting at `slot_cnt`=3726.
- `EN` held high for 53 slots: `GRID` runs 1..52 then 1; `FRAME_START` pulses exactly twice; slot spacing is 3846 cycles; `BLK` is low from `slot_cnt` 0 to 3725 from the second slot on.
- `SWAP_REQ` pulsed at grid 20 and again at grid 40: one `SWAP_ACK` at the next wrap; `RD_BANK` goes 0→1 there and nowhere else.
- `SWAP_REQ` in the boundary cycle: taken at that boundary; with `VFD_SCAN_DBUF_EN` undefined, `RD_BANK` stays 0 and `SWAP_ACK` pulses every frame.
- `EN` dropped at `slot_cnt`=100 of grid 7: the slot completes including `LAT`; then `GRID`=0, `BLK`=1, `SHIFT_EN`=0.
- `RSTN` asserted mid-SHIFT with `RD_BANK`=1: outputs return to reset values asynchronously; the scan restarts at grid 1 with bank 0.
